// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
//
// Parametrised register file with a per-register pending scoreboard and a
// sequential post-reset initialisation sweep. It sits between ID (reads and
// destination issue) and WB (writes).
//
// After reset the file walks every register, writing register i with the
// value i (zero-extended). This takes RegCount cycles. While the sweep runs,
// all outputs are held at zero and writes and issues are ignored.
//
// Optional feature (macro RF_BYPASS_EN): when it is defined, a WB write to
// the register being read is forwarded to readDataN in the same cycle. The
// matching busyN is also cleared in that cycle, unless an issue to the same
// register arrives in that cycle. When the macro is undefined, no forwarding
// paths are built.
//
// Parameters
//   WordLen   data width in bits
//   RegCount  number of architectural registers (1..2^AddrLen)
//   AddrLen   register address width
//
// Ports
//   clk                       sole clock, rising edge
//   rst                       synchronous, active-high reset
//   readRegister1/2           read port addresses
//   readData1/2               read port data (combinational)
//   busy1/2                   pending flag of the addressed register
//   writeRegister/writeData   WB destination and data
//   regWrite                  WB write enable
//   issueDst/issueValid       destination of the instruction leaving ID
//   ready                     sweep complete, port accesses honoured
// ---------------------------------------------------------------------------
module register_file_sb #(
    parameter int WordLen  = 32,
    parameter int RegCount = 15,
    parameter int AddrLen  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AddrLen-1:0] readRegister1,
    input  logic [AddrLen-1:0] readRegister2,
    output logic [WordLen-1:0] readData1,
    output logic [WordLen-1:0] readData2,
    output logic               busy1,
    output logic               busy2,
    input  logic [AddrLen-1:0] writeRegister,
    input  logic [WordLen-1:0] writeData,
    input  logic               regWrite,
    input  logic [AddrLen-1:0] issueDst,
    input  logic               issueValid,
    output logic               ready
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AddrLen-1:0] LAST_IDX = AddrLen'(RegCount - 1);

    state_t              state_reg, state_next;
    logic [AddrLen-1:0]  cnt_reg, cnt_next;
    logic [WordLen-1:0]  reg_file_reg [RegCount];
    logic [RegCount-1:0] pending_reg, pending_next;

    logic                wr_en;
    logic                iss_en;
    logic [RegCount-1:0] wr_hit;
    logic [RegCount-1:0] iss_hit;

    // Read ports are handled as a two-entry array so that both ports share
    // one generated implementation.
    logic [AddrLen-1:0]  rd_addr [2];
    logic [WordLen-1:0]  rd_data [2];
    logic [1:0]          rd_busy;

    function automatic logic in_range(input logic [AddrLen-1:0] addr);
        return {1'b0, addr} < (AddrLen + 1)'(RegCount);
    endfunction

    // Writes and issues are accepted only in RUN and only for existing
    // registers. Out-of-range requests are dropped silently.
    assign wr_en  = (state_reg == RUN) && regWrite   && in_range(writeRegister);
    assign iss_en = (state_reg == RUN) && issueValid && in_range(issueDst);

    // Per-register scoreboard update. An issue takes priority over a write
    // to the same register on the same edge, because the new producer has
    // not yet written back.
    generate
        for (genvar gi = 0; gi < RegCount; gi++) begin : g_pending
            assign wr_hit[gi]       = wr_en  && (writeRegister == AddrLen'(gi));
            assign iss_hit[gi]      = iss_en && (issueDst      == AddrLen'(gi));
            assign pending_next[gi] = iss_hit[gi] | (pending_reg[gi] & ~wr_hit[gi]);
        end
    endgenerate

    // FSM next state and sweep counter
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= INIT;
            cnt_reg     <= '0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
        end
    end

    // Reset does not clear the storage array. The sweep that follows reset
    // initialises it, and reset itself suppresses every write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT) begin
                reg_file_reg[cnt_reg] <= WordLen'(cnt_reg);
            end else if (wr_en) begin
                reg_file_reg[writeRegister] <= writeData;
            end
        end
    end

    assign rd_addr[0] = readRegister1;
    assign rd_addr[1] = readRegister2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = '0;
                rd_busy[gi] = 1'b0;
                if (state_reg == RUN && in_range(rd_addr[gi])) begin
                    rd_data[gi] = reg_file_reg[rd_addr[gi]];
                    rd_busy[gi] = pending_reg[rd_addr[gi]];
`ifdef RF_BYPASS_EN
                    // wr_en already implies RUN and an in-range target.
                    if (wr_en && (writeRegister == rd_addr[gi])) begin
                        rd_data[gi] = writeData;
                        rd_busy[gi] = iss_en && (issueDst == writeRegister);
                    end
`endif
                end
            end
        end
    endgenerate

    assign readData1 = rd_data[0];
    assign readData2 = rd_data[1];
    assign busy1     = rd_busy[0];
    assign busy2     = rd_busy[1];
    assign ready     = (state_reg == RUN);

endmodule

// File: tb/tb_register_file_sb.sv
// ---------------------------------------------------------------------------
// tb_register_file_sb
//
// Directed bench for register_file_sb with the default parameters
// (32-bit words, 15 registers, 4-bit addresses). Inputs change on the
// falling edge, and outputs are checked shortly afterwards. Expected values
// are hand-derived, and some depend on whether RF_BYPASS_EN is defined.
// ---------------------------------------------------------------------------
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  readRegister1, readRegister2;
    logic [31:0] readData1, readData2;
    logic        busy1, busy2;
    logic [3:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [3:0]  issueDst;
    logic        issueValid;
    logic        ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_mem [15];
    logic [14:0] exp_busy;

    register_file_sb #(
        .WordLen (32),
        .RegCount(15),
        .AddrLen (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .readRegister1(readRegister1),
        .readRegister2(readRegister2),
        .readData1    (readData1),
        .readData2    (readData2),
        .busy1        (busy1),
        .busy2        (busy2),
        .writeRegister(writeRegister),
        .writeData    (writeData),
        .regWrite     (regWrite),
        .issueDst     (issueDst),
        .issueValid   (issueValid),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle at the following falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        readRegister1 = 4'd0; readRegister2 = 4'd0;
        writeRegister = 4'd0; writeData = 32'h0; regWrite = 1'b0;
        issueDst = 4'd0; issueValid = 1'b0;

        // ---------------- init sweep ----------------
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        check("rst_busy2", {31'b0, busy2}, 32'd0);
        check("rst_rd2",   readData2, 32'd0);
        for (int i = 0; i < 15; i++) begin
            readRegister1 = 4'(i);
            #1;
            check($sformatf("init_ready_%0d", i), {31'b0, ready}, 32'd0);
            check($sformatf("init_rd1_%0d", i), readData1, 32'd0);
            step();
        end
        check("init_done_ready", {31'b0, ready}, 32'd1);
        for (int i = 0; i < 15; i++) exp_mem[i] = 32'(i);
        exp_busy = '0;

        readRegister1 = 4'd7; readRegister2 = 4'd14;
        #1;
        check("sweep_r7",  readData1, 32'd7);
        check("sweep_r14", readData2, 32'd14);
        check("sweep_busy1", {31'b0, busy1}, 32'd0);

        // ---------------- write / read ----------------
        @(negedge clk);
        regWrite = 1'b1; writeRegister = 4'd3; writeData = 32'hDEADBEEF; readRegister1 = 4'd3;
        #1;
`ifdef RF_BYPASS_EN
        check("wr_same_cycle", readData1, 32'hDEADBEEF);
`else
        check("wr_same_cycle", readData1, 32'd3);
`endif
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        check("wr_next_cycle", readData1, 32'hDEADBEEF);
        exp_mem[3] = 32'hDEADBEEF;

        // ---------------- scoreboard ----------------
        issueValid = 1'b1; issueDst = 4'd5; readRegister1 = 4'd5;
        #1;
        check("iss_same_cycle_busy", {31'b0, busy1}, 32'd0);
        @(negedge clk);
        issueValid = 1'b0;
        #1;
        check("iss_next_busy", {31'b0, busy1}, 32'd1);
        check("iss_next_data", readData1, 32'd5);
        regWrite = 1'b1; writeRegister = 4'd5; writeData = 32'h55;
        #1;
`ifdef RF_BYPASS_EN
        check("wb_same_busy", {31'b0, busy1}, 32'd0);
        check("wb_same_data", readData1, 32'h55);
`else
        check("wb_same_busy", {31'b0, busy1}, 32'd1);
        check("wb_same_data", readData1, 32'd5);
`endif
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        check("wb_next_busy", {31'b0, busy1}, 32'd0);
        check("wb_next_data", readData1, 32'h55);
        exp_mem[5] = 32'h55;

        // ---------------- simultaneous issue + write, same reg ----------------
        issueValid = 1'b1; issueDst = 4'd9;
        regWrite = 1'b1; writeRegister = 4'd9; writeData = 32'h99;
        readRegister1 = 4'd9; readRegister2 = 4'd9;
        #1;
`ifdef RF_BYPASS_EN
        check("sim_same_data", readData1, 32'h99);
        check("sim_same_busy", {31'b0, busy1}, 32'd1);
`else
        check("sim_same_data", readData1, 32'd9);
        check("sim_same_busy", {31'b0, busy1}, 32'd0);
`endif
        @(negedge clk);
        issueValid = 1'b0; regWrite = 1'b0;
        #1;
        check("sim_next_data1", readData1, 32'h99);
        check("sim_next_busy1", {31'b0, busy1}, 32'd1);
        check("sim_next_data2", readData2, 32'h99);
        check("sim_next_busy2", {31'b0, busy2}, 32'd1);
        exp_mem[9] = 32'h99;
        exp_busy[9] = 1'b1;

        // ---------------- issue and write to different regs ----------------
        issueValid = 1'b1; issueDst = 4'd2;
        regWrite = 1'b1; writeRegister = 4'd4; writeData = 32'h44;
        @(negedge clk);
        issueValid = 1'b0; regWrite = 1'b0;
        readRegister1 = 4'd2; readRegister2 = 4'd4;
        #1;
        check("diff_busy_r2", {31'b0, busy1}, 32'd1);
        check("diff_data_r2", readData1, 32'd2);
        check("diff_busy_r4", {31'b0, busy2}, 32'd0);
        check("diff_data_r4", readData2, 32'h44);
        exp_mem[4] = 32'h44;
        exp_busy[2] = 1'b1;

        // ---------------- out-of-range ----------------
        regWrite = 1'b1; writeRegister = 4'd15; writeData = 32'h1234;
        issueValid = 1'b1; issueDst = 4'd15;
        readRegister1 = 4'd15;
        @(negedge clk);
        regWrite = 1'b0; issueValid = 1'b0;
        #1;
        check("oor_data", readData1, 32'd0);
        check("oor_busy", {31'b0, busy1}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            readRegister2 = 4'(i);
            #1;
            check($sformatf("oor_keep_r%0d", i), readData2, exp_mem[i]);
            check($sformatf("oor_busy_r%0d", i), {31'b0, busy2}, {31'b0, exp_busy[i]});
        end

        // ---------------- reset mid-sweep ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        readRegister1 = 4'd7;
        #1;
        check("mid_rst_ready", {31'b0, ready}, 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("mid_sweep6_ready", {31'b0, ready}, 32'd0);
        // Requests during INIT must be ignored.
        regWrite = 1'b1; writeRegister = 4'd1; writeData = 32'hFFFF;
        issueValid = 1'b1; issueDst = 4'd1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("resweep_ready_%0d", i), {31'b0, ready}, 32'd0);
            check($sformatf("resweep_rd1_%0d", i), readData1, 32'd0);
            step();
        end
        regWrite = 1'b0; issueValid = 1'b0;
        check("resweep_done_ready", {31'b0, ready}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            readRegister1 = 4'(i);
            #1;
            check($sformatf("resweep_r%0d", i), readData1, 32'(i));
            check($sformatf("resweep_busy_r%0d", i), {31'b0, busy1}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the 15-entry processor register file. Two asynchronous read ports and one write port, writes on the rising edge. Adds three behaviours:
- a per-register pending scoreboard for hazard detection;
- a sequential post-reset initialisation sweep;
- optional write-to-read forwarding.

It sits between the ID stage (reads, destination issue) and the WB stage (writes).

## Interface
Parameters:
- WordLen, 32, data width in bits
- RegCount, 15, number of architectural registers (1..2^AddrLen)
- AddrLen, 4, register address width

Ports:
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- readRegister1  input  AddrLen  read port 1 address
- readRegister2  input  AddrLen  read port 2 address
- readData1  output  WordLen  read port 1 data
- readData2  output  WordLen  read port 2 data
- busy1  output  1  register at readRegister1 has a pending write
- busy2  output  1  register at readRegister2 has a pending write
- writeRegister  input  AddrLen  WB destination
- writeData  input  WordLen  WB data
- regWrite  input  1  WB write enable
- issueDst  input  AddrLen  destination of instruction leaving ID
- issueValid  input  1  mark issueDst pending
- ready  output  1  initialisation sweep complete; port accesses honoured

## Operation
- **States:** INIT and RUN; 2-state FSM plus sweep counter cnt (AddrLen bits).
- **rst high at an edge:**
  - state <= INIT, cnt <= 0, all pending bits <= 0.
  - Array contents are not cleared by rst itself.
  - rst overrides everything, including mid-sweep; the sweep restarts at 0.
- **INIT:**
  - Each cycle: regFile[cnt] <= cnt, zero-extended to WordLen; cnt <= cnt+1.
  - When cnt == RegCount-1, that write completes and state <= RUN.
  - regWrite and issueValid are ignored.
  - readData1/2, busy1/2 and ready are forced to 0.
- **RUN:**
  - ready = 1.
  - readDataN = regFile[readRegisterN] (combinational).
  - busyN = pending[readRegisterN] (combinational).
  - regWrite: regFile[writeRegister] <= writeData and pending[writeRegister] <= 0.
  - issueValid: pending[issueDst] <= 1.
- **Out-of-range address (>= RegCount):**
  - Reads return 0 with busy 0.
  - Writes and issues are ignored.
- **Same-edge events:**
  - Issue and write to the same register: pending ends 1 (new producer wins); data is still written.
  - Issue and write to different registers: both take effect.
- **Read during write without forwarding:** the old value is returned until the edge; the new value appears the cycle after.
- **Reset values:** ready=0, busy1=busy2=0, readData1=readData2=0. Outputs stay at these values for the whole of INIT.

## Timing
- Read latency 0 (combinational from address).
- Write is visible on reads 1 cycle after regWrite is sampled, or 0 cycles with forwarding (see Configuration).
- Pending set/clear is visible on busyN 1 cycle after the edge.
- Sweep length is exactly RegCount cycles after rst deasserts. With RegCount=15: rst low at edge 0, ready=1 after edge 15.
- No handshake on write or issue; the producer guarantees at most one write and one issue per cycle.

## Configuration
- **Macro RF_BYPASS_EN defined:** in RUN, if regWrite && writeRegister==readRegisterN && writeRegister < RegCount:
  - readDataN = writeData in the same cycle;
  - busyN = 0 in the same cycle, unless issueValid targets the same register in that cycle.
  - Read port 1 and read port 2 forward independently.
- **Macro undefined:** no forwarding paths are built. Reads and busy reflect only registered state.

## Test plan
- **Init sweep:** hold rst 2 cycles, release, RegCount=15.
  - ready=0 and readData1=0 for 15 cycles; ready=1 after edge 15.
  - Then readRegister1=7 -> readData1=7 and readRegister2=14 -> readData2=14.
- **Write/read:** regWrite, writeRegister=3, writeData=0xDEADBEEF, readRegister1=3.
  - Without RF_BYPASS_EN: old value 3 that cycle, 0xDEADBEEF the next.
  - With RF_BYPASS_EN: 0xDEADBEEF in the same cycle.
- **Scoreboard:** issueValid with issueDst=5 -> busy1=1 for readRegister1=5 from the next cycle.
  - Later regWrite to r5 with 0x55 -> busy1=0 and readData1=0x55 the cycle after.
  - With RF_BYPASS_EN: both already true in the write cycle.
- **Simultaneous issue+write:** issueValid to r9 and regWrite to r9 with 0x99 on the same edge -> readData=0x99, busy=1 afterwards.
- **Out-of-range:** regWrite to r15 with 0x1234 and issueDst=15 -> readRegister1=15 gives 0, busy1=0; r0..r14 unchanged.
- **Reset mid-sweep:** assert rst at sweep cycle 6 -> ready stays 0; full 15-cycle sweep restarts; all pending bits 0 afterwards.
